// File: rtl/sharpen_lane_unit_if.sv
// Operand, handshake and result bundle for the sharpening lane unit.
// The master drives the request and operands. The slave returns status and the result.
interface sharpen_lane_unit_if;
  logic        start;
  logic [31:0] center;
  logic [31:0] up;
  logic [31:0] down;
  logic [31:0] left;
  logic [31:0] right;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, center, up, down, left, right,
    input  busy, done, result
  );

  modport slave (
    input  start, center, up, down, left, right,
    output busy, done, result
  );
endinterface

// File: rtl/sharpen_lane_unit.sv
// Multi-cycle 5C-U-D-L-R cross sharpening on four packed 8-bit lanes, with saturation.
// There is one accumulator per lane. The lanes share no carry or borrow.
module sharpen_lane_unit #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 12
) (
  input logic               clk,
  input logic               rst_n,
  sharpen_lane_unit_if.slave bus
);
  localparam int WORD_W = PIX_W * LANES;

  typedef enum logic [2:0] {IDLE, MUL, SUB_U, SUB_D, SUB_L, SUB_R, SAT} state_t;

  state_t                      state;
  logic [WORD_W-1:0]           c_op, u_op, d_op, l_op, r_op;
  logic [LANES-1:0][ACC_W-1:0] acc;
  logic [LANES-1:0][ACC_W-1:0] acc_mul;
  logic [LANES-1:0][ACC_W-1:0] acc_sub;
  logic [1:0]                  sel;
  logic [WORD_W-1:0]           nb_word;
  logic [WORD_W-1:0]           sat_word;
  logic [WORD_W-1:0]           result_q;
  logic                        busy_q;
  logic                        done_q;

  always_comb begin
    sel = 2'd0;
    case (state)
      SUB_D:   sel = 2'd1;
      SUB_L:   sel = 2'd2;
      SUB_R:   sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  always_comb begin
    nb_word = u_op;
    case (sel)
      2'd0: nb_word = u_op;
      2'd1: nb_word = d_op;
      2'd2: nb_word = l_op;
      2'd3: nb_word = r_op;
      default: nb_word = u_op;
    endcase
  end

  // The accumulator MSB is the sign. Any set bit between the sign and the pixel bits means the value is above 255.
  always_comb begin
    acc_mul  = '0;
    acc_sub  = '0;
    sat_word = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_mul[i] = (ACC_W'(c_op[i*PIX_W +: PIX_W]) << 2) + ACC_W'(c_op[i*PIX_W +: PIX_W]);
      acc_sub[i] = acc[i] - ACC_W'(nb_word[i*PIX_W +: PIX_W]);
      if (acc[i][ACC_W-1])
        sat_word[i*PIX_W +: PIX_W] = '0;
      else if (|acc[i][ACC_W-2:PIX_W])
        sat_word[i*PIX_W +: PIX_W] = '1;
      else
        sat_word[i*PIX_W +: PIX_W] = acc[i][PIX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      c_op     <= '0;
      u_op     <= '0;
      d_op     <= '0;
      l_op     <= '0;
      r_op     <= '0;
      acc      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            c_op  <= bus.center;
            u_op  <= bus.up;
            d_op  <= bus.down;
            l_op  <= bus.left;
            r_op  <= bus.right;
            state <= MUL;
          end
        end
        MUL: begin
          acc    <= acc_mul;
          busy_q <= 1'b1;
          state  <= SUB_U;
        end
        SUB_U: begin
          acc   <= acc_sub;
          state <= SUB_D;
        end
        SUB_D: begin
          acc   <= acc_sub;
          state <= SUB_L;
        end
        SUB_L: begin
          acc   <= acc_sub;
          state <= SUB_R;
        end
        SUB_R: begin
          acc   <= acc_sub;
          state <= SAT;
        end
        SAT: begin
          result_q <= sat_word;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_sharpen_lane_unit.sv
// Directed scoreboard bench for sharpen_lane_unit.
// Expected words are queued when a start is driven and compared when done pulses.
module tb_sharpen_lane_unit;
  logic clk;
  logic rst_n;
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  logic [31:0] expQ[$];

  sharpen_lane_unit_if bus();

  sharpen_lane_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] sharpenModel(input logic [31:0] c, u, d, l, r);
    logic [31:0] res;
    int v;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      v = 5 * int'(c[i*8 +: 8]) - int'(u[i*8 +: 8]) - int'(d[i*8 +: 8])
          - int'(l[i*8 +: 8]) - int'(r[i*8 +: 8]);
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      res[i*8 +: 8] = v[7:0];
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setOperands(input logic [31:0] c, u, d, l, r);
    bus.center = c;
    bus.up     = u;
    bus.down   = d;
    bus.left   = l;
    bus.right  = r;
  endtask

  // Drive a one-cycle start on a negedge and queue its expected word. Return on the negedge after the accepting edge.
  task automatic applyStimulus(input logic [31:0] c, u, d, l, r, input logic [31:0] expWord);
    setOperands(c, u, d, l, r);
    bus.start = 1'b1;
    expQ.push_back(expWord);
    @(negedge clk);
    bus.start = 1'b0;
    setOperands($urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic waitDone(input string tag, input int expLat, input int expBusy);
    int lat;
    int busyCycles;
    bit gotDone;
    logic [31:0] expWord;
    lat = 0;
    busyCycles = 0;
    gotDone = 1'b0;
    for (int k = 0; k < 30 && !gotDone; k++) begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.done === 1'b1) gotDone = 1'b1;
    end
    checkOutput({tag, " done seen"}, 32'(gotDone), 32'd1);
    if (gotDone) begin
      if (expQ.size() > 0) expWord = expQ.pop_front();
      else expWord = 32'hxxxxxxxx;
      checkOutput({tag, " result"}, bus.result, expWord);
      checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(expBusy));
      checkOutput({tag, " busy low at done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      checkOutput({tag, " done single pulse"}, 32'(bus.done), 32'd0);
      checkOutput({tag, " result held"}, bus.result, expWord);
    end
  endtask

  initial begin
    logic [31:0] holdExp;
    logic [31:0] firstExp;
    int doneCount;
    int donePos[$];
    bit stableErr;

    rst_n = 1'b0;
    bus.start = 1'b0;
    setOperands('0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] uniform image");
    applyStimulus(32'h40404040, 32'h40404040, 32'h40404040, 32'h40404040, 32'h40404040, 32'h40404040);
    waitDone("uniform", 6, 5);

    $display("[TB] saturation high");
    applyStimulus(32'hFFFFFFFF, 0, 0, 0, 0, 32'hFFFFFFFF);
    waitDone("sat ff", 6, 5);
    applyStimulus(32'h33333333, 0, 0, 0, 0, 32'hFFFFFFFF);
    waitDone("sat 255 boundary", 6, 5);
    applyStimulus(32'h01020304, 32'h01000000, 32'h00020000, 32'h00000300, 32'h00000004,
                  sharpenModel(32'h01020304, 32'h01000000, 32'h00020000, 32'h00000300, 32'h00000004));
    waitDone("small lanes", 6, 5);

    $display("[TB] saturation low and mixed lanes");
    applyStimulus(32'h00108034, 32'h0104000D, 32'h0104000D, 32'h0104000D, 32'h0104000D, 32'h0040FFD0);
    waitDone("mixed", 6, 5);
    applyStimulus(32'h00108034, 32'h04100034, 0, 0, 0, 32'h0040FFD0);
    waitDone("mixed up only", 6, 5);
    applyStimulus(32'h00108034, 0, 0, 0, 32'h04100034, 32'h0040FFD0);
    waitDone("mixed right only", 6, 5);
    applyStimulus(32'h80FF0190, 32'h10000100, 32'h20000020, 32'h05000003, 32'h01FF0080,
                  sharpenModel(32'h80FF0190, 32'h10000100, 32'h20000020, 32'h05000003, 32'h01FF0080));
    waitDone("model mix", 6, 5);

    $display("[TB] start during busy");
    firstExp = sharpenModel(32'h20202020, 32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010);
    applyStimulus(32'h20202020, 32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010, firstExp);
    @(negedge clk);
    setOperands(32'hFFFFFFFF, 0, 0, 0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("busy start ignored", 4, 3);
    doneCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneCount++;
    end
    checkOutput("busy start no extra done", 32'(doneCount), 32'd0);
    checkOutput("busy start result kept", bus.result, firstExp);

    $display("[TB] reset during SUB_L");
    applyStimulus(32'h40404040, 0, 0, 0, 0, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort result", bus.result, 32'd0);
    void'(expQ.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) doneCount++;
    end
    checkOutput("abort no resume", 32'(doneCount), 32'd0);
    applyStimulus(32'h10203040, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
                  sharpenModel(32'h10203040, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404));
    waitDone("after reset", 6, 5);

    $display("[TB] start held high");
    holdExp = sharpenModel(32'h30405060, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    setOperands(32'h30405060, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
    repeat (3) expQ.push_back(holdExp);
    bus.start = 1'b1;
    stableErr = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 20) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        donePos.push_back(k);
        if (expQ.size() > 0) checkOutput("held result", bus.result, expQ.pop_front());
        else checkOutput("held extra done", 32'(k), 32'd0);
      end else if (k > 7 && bus.result !== holdExp) begin
        stableErr = 1'b1;
      end
    end
    checkOutput("held done count", 32'(donePos.size()), 32'd3);
    if (donePos.size() == 3) begin
      checkOutput("held done 1 pos", 32'(donePos[0]), 32'd7);
      checkOutput("held done 2 pos", 32'(donePos[1]), 32'd14);
      checkOutput("held done 3 pos", 32'(donePos[2]), 32'd21);
    end
    checkOutput("held result stable", 32'(stableErr), 32'd0);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
